// File: rtl/regfile_mp_bypass_if.sv
// Register-file access bus: read ports, ALU/load writeback ports, and the
// load-pending scoreboard. The pipeline drives it as master and the file is the slave.
interface regfile_mp_bypass_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [NRD*AW-1:0]    raddr;
    logic [NRD*WIDTH-1:0] rdata;
    logic [NRD-1:0]       rbusy;
    logic                 we0;
    logic [AW-1:0]        waddr0;
    logic [WIDTH-1:0]     wdata0;
    logic                 we1;
    logic [AW-1:0]        waddr1;
    logic [WIDTH-1:0]     wdata1;
    logic                 mark_en;
    logic [AW-1:0]        mark_addr;
    logic [DEPTH-1:0]     busy_vec;

    modport master (
        output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, mark_en, mark_addr,
        input  rdata, rbusy, busy_vec
    );

    modport slave (
        input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, mark_en, mark_addr,
        output rdata, rbusy, busy_vec
    );
endinterface

// File: rtl/regfile_mp_bypass.sv
// Multi-port register file with two write ports, same-cycle write-to-read bypass,
// a hardwired zero register and a per-register pending-load scoreboard.
module regfile_mp_bypass #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = DEPTH - 1
) (
    input  logic               clk,
    input  logic               reset_n,
    regfile_mp_bypass_if.slave bus
);
    localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);

    logic [WIDTH-1:0]     regs_q [DEPTH];
    logic [WIDTH-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_d;
    logic [NRD*WIDTH-1:0] rdata;
    logic [NRD-1:0]       rbusy;
    logic [AW-1:0]        ra;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (bus.we0 && bus.waddr0 != ZADDR) regs_d[bus.waddr0] = bus.wdata0;
        // Port 1 applied last: the load result is younger and wins a collision.
        if (bus.we1 && bus.waddr1 != ZADDR) regs_d[bus.waddr1] = bus.wdata1;
        if (bus.we1) busy_d[bus.waddr1] = 1'b0;
        // Mark after clear: a new load issued as the old one completes stays pending.
        if (bus.mark_en && bus.mark_addr != ZADDR) busy_d[bus.mark_addr] = 1'b1;
        busy_d[ZADDR] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            ra = bus.raddr[p*AW +: AW];
            if (ra == ZADDR)
                rdata[p*WIDTH +: WIDTH] = '0;
            else if (bus.we1 && bus.waddr1 == ra)
                rdata[p*WIDTH +: WIDTH] = bus.wdata1;
            else if (bus.we0 && bus.waddr0 == ra)
                rdata[p*WIDTH +: WIDTH] = bus.wdata0;
            else
                rdata[p*WIDTH +: WIDTH] = regs_q[ra];
            rbusy[p] = busy_q[ra] & ~(bus.we1 && bus.waddr1 == ra);
        end
    end

    assign bus.rdata    = rdata;
    assign bus.rbusy    = rbusy;
    assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Scoreboard bench for regfile_mp_bypass: a default 64x32/2R instance with XZR=31
// and a 32x16/3R instance with zero register 0.
module tb_regfile_mp_bypass;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_bypass_if #(.WIDTH(64), .DEPTH(32), .NRD(2)) bus_a ();
    regfile_mp_bypass_if #(.WIDTH(32), .DEPTH(16), .NRD(3)) bus_b ();

    regfile_mp_bypass #(.WIDTH(64), .DEPTH(32), .NRD(2), .ZERO_REG(31)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );
    regfile_mp_bypass #(.WIDTH(32), .DEPTH(16), .NRD(3), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    // kind: 0 A rdata[idx], 1 A rbusy[idx], 2 A busy_vec[idx], 3 B rdata[idx], 4 A busy_vec
    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [63:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;

    logic [63:0] m_reg [32];
    logic [31:0] m_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int kind, input int idx);
        case (kind)
            0: return bus_a.rdata[idx*64 +: 64];
            1: return {63'b0, bus_a.rbusy[idx]};
            2: return {63'b0, bus_a.busy_vec[idx]};
            3: return {32'b0, bus_b.rdata[idx*32 +: 32]};
            default: return {32'b0, bus_a.busy_vec};
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input int idx, input logic [63:0] exp);
        exp_t e;
        e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.kind, e.idx), e.exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_a.we0 = 1'b0; bus_a.we1 = 1'b0; bus_a.mark_en = 1'b0;
        bus_b.we0 = 1'b0; bus_b.we1 = 1'b0; bus_b.mark_en = 1'b0;
    endtask

    task automatic set_raddr_a(input int a0, input int a1);
        bus_a.raddr = {5'(a1), 5'(a0)};
    endtask

    task automatic set_raddr_b(input int a);
        bus_b.raddr = {3{4'(a)}};
    endtask

    task automatic push_b_all(input string tag, input logic [31:0] exp);
        for (int p = 0; p < 3; p++) push(tag, 3, p, {32'b0, exp});
    endtask

    initial begin
        logic [63:0] exp_rd;
        int ra;
        bus_a.raddr = '0; bus_a.waddr0 = '0; bus_a.wdata0 = '0; bus_a.waddr1 = '0;
        bus_a.wdata1 = '0; bus_a.mark_addr = '0;
        bus_b.raddr = '0; bus_b.waddr0 = '0; bus_b.wdata0 = '0; bus_b.waddr1 = '0;
        bus_b.wdata1 = '0; bus_b.mark_addr = '0;
        idle_all();

        // 1: async reset asserted mid-cycle, then every address reads 0
        #12 reset_n = 1'b0;
        push("reset_busy_vec", 4, 0, 64'h0);
        sample();
        next_cycle();
        reset_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            set_raddr_a(a, 31 - a);
            set_raddr_b(a % 16);
            push("reset_rd0", 0, 0, 64'h0);
            push("reset_rd1", 0, 1, 64'h0);
            push_b_all("reset_b_rd", 32'h0);
            if (a == 0) push("reset_busy_vec_rel", 4, 0, 64'h0);
            sample();
            next_cycle();
        end

        // 2: write with same-cycle bypass, then read from storage
        bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd5; bus_a.wdata0 = 64'hDEAD_BEEF_0123_4567;
        set_raddr_a(5, 5);
        push("bypass_w0_p0", 0, 0, 64'hDEAD_BEEF_0123_4567);
        push("bypass_w0_p1", 0, 1, 64'hDEAD_BEEF_0123_4567);
        sample(); next_cycle();
        bus_a.we0 = 1'b0;
        push("stored_p0", 0, 0, 64'hDEAD_BEEF_0123_4567);
        push("stored_p1", 0, 1, 64'hDEAD_BEEF_0123_4567);
        sample(); next_cycle();

        // 3: writes to XZR dropped on both ports
        bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd31; bus_a.wdata0 = '1;
        set_raddr_a(31, 5);
        push("xzr_w0_bypass", 0, 0, 64'h0);
        sample(); next_cycle();
        bus_a.we0 = 1'b0;
        push("xzr_w0_after", 0, 0, 64'h0);
        sample(); next_cycle();
        bus_a.we1 = 1'b1; bus_a.waddr1 = 5'd31; bus_a.wdata1 = '1;
        push("xzr_w1_bypass", 0, 0, 64'h0);
        sample(); next_cycle();
        bus_a.we1 = 1'b0;
        push("xzr_w1_after", 0, 0, 64'h0);
        push("xzr_keeps_r5", 0, 1, 64'hDEAD_BEEF_0123_4567);
        sample(); next_cycle();

        // 4: collision, port 1 wins for bypass and storage
        bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd7; bus_a.wdata0 = 64'h1;
        bus_a.we1 = 1'b1; bus_a.waddr1 = 5'd7; bus_a.wdata1 = 64'h2;
        set_raddr_a(7, 7);
        push("collide_bypass_p0", 0, 0, 64'h2);
        push("collide_bypass_p1", 0, 1, 64'h2);
        sample(); next_cycle();
        idle_all();
        push("collide_stored", 0, 0, 64'h2);
        sample(); next_cycle();

        // 5: scoreboard mark / clear / simultaneous
        bus_a.mark_en = 1'b1; bus_a.mark_addr = 5'd9;
        set_raddr_a(9, 9);
        push("mark_not_yet", 2, 9, 64'h0);
        sample(); next_cycle();
        bus_a.mark_en = 1'b0;
        push("mark_busy_vec", 2, 9, 64'h1);
        push("mark_rbusy1", 1, 1, 64'h1);
        push("mark_rbusy0", 1, 0, 64'h1);
        sample(); next_cycle();
        bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd9; bus_a.wdata0 = 64'h77;
        push("we0_no_clear_rbusy", 1, 1, 64'h1);
        sample(); next_cycle();
        bus_a.we0 = 1'b0;
        push("we0_no_clear_vec", 2, 9, 64'h1);
        sample(); next_cycle();
        bus_a.we1 = 1'b1; bus_a.waddr1 = 5'd9; bus_a.wdata1 = 64'h55;
        push("clear_rbusy_same", 1, 1, 64'h0);
        push("clear_vec_before", 2, 9, 64'h1);
        push("clear_bypass", 0, 1, 64'h55);
        sample(); next_cycle();
        bus_a.we1 = 1'b0;
        push("clear_vec_after", 2, 9, 64'h0);
        push("clear_rbusy_after", 1, 1, 64'h0);
        sample(); next_cycle();
        bus_a.mark_en = 1'b1; bus_a.mark_addr = 5'd9;
        sample(); next_cycle();
        bus_a.we1 = 1'b1; bus_a.waddr1 = 5'd9; bus_a.wdata1 = 64'h66;
        push("simul_rbusy_same", 1, 1, 64'h0);
        sample(); next_cycle();
        idle_all();
        push("simul_set_wins", 2, 9, 64'h1);
        push("simul_rbusy_after", 1, 1, 64'h1);
        push("simul_data", 0, 1, 64'h66);
        sample(); next_cycle();
        bus_a.mark_en = 1'b1; bus_a.mark_addr = 5'd31;
        sample(); next_cycle();
        bus_a.mark_en = 1'b0;
        push("mark_xzr_ignored", 2, 31, 64'h0);
        sample(); next_cycle();

        // reset during a write loses it and clears the scoreboard
        bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd3; bus_a.wdata0 = 64'hAAAA;
        next_cycle();
        bus_a.waddr0 = 5'd6; bus_a.wdata0 = 64'hBBBB;
        bus_a.mark_en = 1'b1; bus_a.mark_addr = 5'd4;
        #2 reset_n = 1'b0;
        next_cycle();
        idle_all();
        set_raddr_a(3, 6);
        push("rst_mid_r3", 0, 0, 64'h0);
        push("rst_mid_r6", 0, 1, 64'h0);
        push("rst_mid_busy", 4, 0, 64'h0);
        sample(); next_cycle();
        reset_n = 1'b1;

        // 6: 32x16/3R instance, zero register is 0
        bus_b.we0 = 1'b1; bus_b.waddr0 = 4'd5; bus_b.wdata0 = 32'hDEAD_BEEF;
        set_raddr_b(5);
        push_b_all("b_bypass", 32'hDEAD_BEEF);
        sample(); next_cycle();
        bus_b.we0 = 1'b0;
        push_b_all("b_stored", 32'hDEAD_BEEF);
        sample(); next_cycle();
        bus_b.we0 = 1'b1; bus_b.waddr0 = 4'd7; bus_b.wdata0 = 32'h1;
        bus_b.we1 = 1'b1; bus_b.waddr1 = 4'd7; bus_b.wdata1 = 32'h2;
        set_raddr_b(7);
        push_b_all("b_collide_bypass", 32'h2);
        sample(); next_cycle();
        idle_all();
        push_b_all("b_collide_stored", 32'h2);
        sample(); next_cycle();
        bus_b.we0 = 1'b1; bus_b.waddr0 = 4'd0; bus_b.wdata0 = '1;
        bus_b.we1 = 1'b1; bus_b.waddr1 = 4'd15; bus_b.wdata1 = 32'hF00D_0015;
        set_raddr_b(0);
        push_b_all("b_zero_bypass", 32'h0);
        sample(); next_cycle();
        idle_all();
        push_b_all("b_zero_after", 32'h0);
        sample(); next_cycle();
        set_raddr_b(15);
        push_b_all("b_top_reg", 32'hF00D_0015);
        sample(); next_cycle();

        // random traffic on instance A against a reference model, from reset
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_busy = '0;
        for (int c = 0; c < 300; c++) begin
            bus_a.we0 = 1'($urandom_range(0, 1));
            bus_a.waddr0 = 5'($urandom_range(24, 31));
            bus_a.wdata0 = {$urandom, $urandom};
            bus_a.we1 = 1'($urandom_range(0, 1));
            bus_a.waddr1 = 5'($urandom_range(24, 31));
            bus_a.wdata1 = {$urandom, $urandom};
            bus_a.mark_en = 1'($urandom_range(0, 1));
            bus_a.mark_addr = 5'($urandom_range(24, 31));
            set_raddr_a($urandom_range(24, 31), $urandom_range(24, 31));
            for (int p = 0; p < 2; p++) begin
                ra = (p == 0) ? int'(bus_a.raddr[4:0]) : int'(bus_a.raddr[9:5]);
                if (ra == 31) exp_rd = 64'h0;
                else if (bus_a.we1 && int'(bus_a.waddr1) == ra) exp_rd = bus_a.wdata1;
                else if (bus_a.we0 && int'(bus_a.waddr0) == ra) exp_rd = bus_a.wdata0;
                else exp_rd = m_reg[ra];
                push("rand_rdata", 0, p, exp_rd);
                push("rand_rbusy", 1, p,
                     {63'b0, m_busy[ra] && !(bus_a.we1 && int'(bus_a.waddr1) == ra)});
            end
            push("rand_busy_vec", 4, 0, {32'b0, m_busy});
            sample();
            if (bus_a.we0 && bus_a.waddr0 != 5'd31) m_reg[bus_a.waddr0] = bus_a.wdata0;
            if (bus_a.we1 && bus_a.waddr1 != 5'd31) m_reg[bus_a.waddr1] = bus_a.wdata1;
            if (bus_a.we1) m_busy[bus_a.waddr1] = 1'b0;
            if (bus_a.mark_en && bus_a.mark_addr != 5'd31) m_busy[bus_a.mark_addr] = 1'b1;
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_mp_bypass.md
Name: regfile_mp_bypass

Overview:
Parametrised multi-port register file for the pipelined LEGv8 core, succeeding the fixed 32x64 2R1W file in the RF stage. It adds configurable width, depth and read-port count, and two write ports (ALU writeback and load writeback). It provides same-cycle write-to-read bypass, a hardwired zero register, asynchronous clear, and a per-register pending-write scoreboard used by the hazard unit to detect load-use stalls.

Parameters:
WIDTH, 64, data width in bits
DEPTH, 32, number of architectural registers (power of two, >=2)
AW, $clog2(DEPTH), register address width (derived; do not override)
NRD, 2, number of read ports (1..4)
ZERO_REG, DEPTH-1, index hardwired to zero (XZR = 31)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
raddr  in  NRD*AW  read addresses; port p uses bits [p*AW +: AW]
rdata  out  NRD*WIDTH  read data; port p uses bits [p*WIDTH +: WIDTH]
rbusy  out  NRD  port p's register has a pending write outstanding
we0  in  1  write enable, port 0 (ALU writeback)
waddr0  in  AW  write address, port 0
wdata0  in  WIDTH  write data, port 0
we1  in  1  write enable, port 1 (load writeback)
waddr1  in  AW  write address, port 1
wdata1  in  WIDTH  write data, port 1
mark_en  in  1  set scoreboard bit (load issued to MEM)
mark_addr  in  AW  register to mark busy
busy_vec  out  DEPTH  full scoreboard, bit r = register r pending

Behaviour:
- Reset (reset_n=0, async): all registers clear to 0 and all scoreboard bits clear. Outputs settle combinationally: rdata=0, rbusy=0, busy_vec=0. Reset is effective mid-write: a write in the same cycle as reset assertion is lost.
- Storage: DEPTH x WIDTH flops, updated on the rising clk edge when reset_n=1.
- Write: if weN=1 and waddrN != ZERO_REG, then reg[waddrN] <= wdataN at the edge. Writes to ZERO_REG are silently dropped.
- Write collision (we0 & we1 & waddr0==waddr1): port 1 wins, because the load result is younger in program order. Port 0 data is discarded.
- Read: combinational, zero latency.
  - rdata[p] = 0 if raddr[p]==ZERO_REG.
  - Otherwise, if we1 and waddr1==raddr[p], rdata[p] = wdata1 (bypass).
  - Otherwise, if we0 and waddr0==raddr[p], rdata[p] = wdata0 (bypass).
  - Otherwise, rdata[p] = reg[raddr[p]].
  - Bypass priority therefore mirrors collision priority.
- Scoreboard (DEPTH bits, bit ZERO_REG is constant 0):
  - mark_en=1 and mark_addr != ZERO_REG sets bit mark_addr at the edge.
  - we1=1 clears bit waddr1 at the edge. we0 does not clear.
  - Simultaneous mark and clear to the same register: set wins, since a new load was issued after the old one completed.
  - Marking an already-busy register keeps it busy; there is no counting.
- rbusy[p] = busy_vec[raddr[p]] & ~(we1 & waddr1==raddr[p]). A completing load is therefore not reported busy in its writeback cycle, because its data is being bypassed.
- No internal pipelining. All state changes take one cycle; all reads are combinational.
- Width rules: addresses >= DEPTH cannot occur because AW is derived. Data is passed through unmodified with no sign extension.

Test Plan:
1. Reset then read: assert reset_n=0 mid-cycle, then release. Read all 32 addresses on both ports -> every rdata=0, busy_vec=0.
2. Write/read and bypass:
   - we0, waddr0=5, wdata0=64'hDEAD_BEEF_0123_4567, raddr[0]=5 in the same cycle -> rdata[0]=that value combinationally.
   - Next cycle with we0=0 -> rdata[0] still reads that value from storage.
3. Zero register: we0, waddr0=31, wdata0=all ones -> rdata for raddr=31 stays 0 in that cycle and after. we1 to 31 behaves the same.
4. Collision: we0 (waddr0=7, wdata0=64'h1) and we1 (waddr1=7, wdata1=64'h2) together -> bypass rdata=64'h2, and the stored value afterwards is 64'h2.
5. Scoreboard:
   - mark_en, mark_addr=9 -> busy_vec[9]=1 next cycle, and rbusy[1]=1 for raddr[1]=9.
   - Two cycles later, we1, waddr1=9 -> rbusy[1]=0 in that same cycle, busy_vec[9]=0 after the edge.
   - Repeat with mark_en and we1 both on 9 in the same cycle -> busy_vec[9] remains 1.
6. Parametrisation: instantiate WIDTH=32, DEPTH=16, NRD=3, ZERO_REG=0. Run scenarios 2 and 4 on all three ports -> same results; register 0 reads 0.
